// File: rtl/generic_table_mem.sv
// rtl/generic_table_mem.sv - table storage responder with register req/ack, lookup port, INIT zero-fill (optional GENERIC_TABLE_PARITY_EN)
module generic_table_mem #(
   parameter int TABLE_ENTRY_WIDTH = 8,
   parameter int TABLE_ADDR_WIDTH  = 8,
   parameter int TABLE_DEPTH       = 256,
   parameter int MAX_DEFER         = 4
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         table_rd_req,
   output logic                         table_rd_ack,
   input  logic [TABLE_ADDR_WIDTH-1:0]  table_rd_addr,
   output logic [TABLE_ENTRY_WIDTH-1:0] table_rd_data,
   input  logic                         table_wr_req,
   output logic                         table_wr_ack,
   input  logic [TABLE_ADDR_WIDTH-1:0]  table_wr_addr,
   input  logic [TABLE_ENTRY_WIDTH-1:0] table_wr_data,
   input  logic                         lookup_req,
   input  logic [TABLE_ADDR_WIDTH-1:0]  lookup_addr,
   output logic                         lookup_rdy,
   output logic                         lookup_vld,
   output logic [TABLE_ENTRY_WIDTH-1:0] lookup_data
`ifdef GENERIC_TABLE_PARITY_EN
   ,
   output logic                         parity_err
`endif
);

   localparam int EW = TABLE_ENTRY_WIDTH;
   localparam int AW = TABLE_ADDR_WIDTH;
   localparam int DW = (MAX_DEFER < 1) ? 1 : $clog2(MAX_DEFER + 1);
`ifdef GENERIC_TABLE_PARITY_EN
   localparam int MEM_W = EW + 1;
`else
   localparam int MEM_W = EW;
`endif
   localparam logic [AW:0]   DEPTH_LIM = (AW + 1)'(TABLE_DEPTH);
   localparam logic [AW-1:0] LAST_ADDR = AW'(TABLE_DEPTH - 1);
   localparam logic [DW-1:0] DEFER_MAX = DW'(MAX_DEFER);

   typedef enum logic [1:0] {
      ST_INIT   = 2'd0,
      ST_IDLE   = 2'd1,
      ST_WR_ACK = 2'd2,
      ST_RD_ACK = 2'd3
   } state_t;

   logic [MEM_W-1:0] mem [TABLE_DEPTH];

   state_t          state_q, state_d;
   logic [AW-1:0]   sweep_addr_q, sweep_addr_d;
   logic [DW-1:0]   defer_q, defer_d;
   logic            wr_ack_q, wr_ack_d;
   logic            rd_ack_q, rd_ack_d;
   logic [EW-1:0]   rd_data_q, rd_data_d;
   logic            lk_vld_q, lk_vld_d;
   logic [EW-1:0]   lk_data_q, lk_data_d;
`ifdef GENERIC_TABLE_PARITY_EN
   logic            parity_err_q, parity_err_d;
`endif

   logic            mem_we;
   logic [AW-1:0]   mem_waddr;
   logic [MEM_W-1:0] mem_wdata;
   logic [MEM_W-1:0] wr_entry;
   logic [MEM_W-1:0] rd_entry;
   logic [MEM_W-1:0] lk_entry;
   logic            wr_in_range;
   logic            rd_in_range;
   logic            lk_in_range;
   logic            reg_pending;
   logic            lk_acc;

   // Address range decode and entry fetch; out-of-range reads return zero
   always_comb begin
      wr_in_range = ({1'b0, table_wr_addr} < DEPTH_LIM);
      rd_in_range = ({1'b0, table_rd_addr} < DEPTH_LIM);
      lk_in_range = ({1'b0, lookup_addr} < DEPTH_LIM);
      rd_entry    = rd_in_range ? mem[table_rd_addr] : '0;
      lk_entry    = lk_in_range ? mem[lookup_addr] : '0;
`ifdef GENERIC_TABLE_PARITY_EN
      wr_entry    = {^table_wr_data, table_wr_data};
`else
      wr_entry    = table_wr_data;
`endif
   end

   // Next-state, arbitration between lookups and register accesses, and output values
   always_comb begin
      state_d      = state_q;
      sweep_addr_d = sweep_addr_q;
      defer_d      = defer_q;
      wr_ack_d     = 1'b0;
      rd_ack_d     = 1'b0;
      rd_data_d    = rd_data_q;
      lk_vld_d     = 1'b0;
      lk_data_d    = lk_data_q;
`ifdef GENERIC_TABLE_PARITY_EN
      parity_err_d = 1'b0;
`endif
      mem_we       = 1'b0;
      mem_waddr    = table_wr_addr;
      mem_wdata    = wr_entry;
      lookup_rdy   = 1'b0;
      lk_acc       = 1'b0;
      reg_pending  = table_wr_req | table_rd_req;

      case (state_q)
         ST_INIT: begin
            // Zero-fill one entry per cycle; all-zero is valid even parity
            mem_we    = 1'b1;
            mem_waddr = sweep_addr_q;
            mem_wdata = '0;
            if (sweep_addr_q == LAST_ADDR) begin
               sweep_addr_d = '0;
               state_d      = ST_IDLE;
            end else begin
               sweep_addr_d = sweep_addr_q + 1'b1;
            end
         end
         ST_IDLE: begin
            // A register request starved MAX_DEFER times takes this cycle outright
            lookup_rdy = (defer_q != DEFER_MAX);
            lk_acc     = lookup_req & lookup_rdy;
            if (lk_acc) begin
               if (reg_pending) begin
                  defer_d = defer_q + 1'b1;
               end
            end else if (table_wr_req) begin
               mem_we   = wr_in_range;
               wr_ack_d = 1'b1;
               defer_d  = '0;
               state_d  = ST_WR_ACK;
            end else if (table_rd_req) begin
               rd_data_d = rd_entry[EW-1:0];
`ifdef GENERIC_TABLE_PARITY_EN
               parity_err_d = rd_in_range & (^rd_entry);
`endif
               rd_ack_d  = 1'b1;
               defer_d   = '0;
               state_d   = ST_RD_ACK;
            end else begin
               defer_d = '0;
            end
         end
         ST_WR_ACK, ST_RD_ACK: begin
            // Requester still holds req here; ignoring it prevents a double ack
            lookup_rdy = 1'b1;
            lk_acc     = lookup_req;
            state_d    = ST_IDLE;
         end
         default: begin
            state_d = ST_INIT;
         end
      endcase

      if (lk_acc) begin
         lk_vld_d  = 1'b1;
         lk_data_d = lk_entry[EW-1:0];
`ifdef GENERIC_TABLE_PARITY_EN
         parity_err_d = parity_err_d | (lk_in_range & (^lk_entry));
`endif
      end
   end

   // Table storage; lookups in the same cycle see the pre-write contents
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   // Control and output registers; reset restarts the zero-fill sweep
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_INIT;
         sweep_addr_q <= '0;
         defer_q      <= '0;
         wr_ack_q     <= 1'b0;
         rd_ack_q     <= 1'b0;
         rd_data_q    <= '0;
         lk_vld_q     <= 1'b0;
         lk_data_q    <= '0;
`ifdef GENERIC_TABLE_PARITY_EN
         parity_err_q <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         sweep_addr_q <= sweep_addr_d;
         defer_q      <= defer_d;
         wr_ack_q     <= wr_ack_d;
         rd_ack_q     <= rd_ack_d;
         rd_data_q    <= rd_data_d;
         lk_vld_q     <= lk_vld_d;
         lk_data_q    <= lk_data_d;
`ifdef GENERIC_TABLE_PARITY_EN
         parity_err_q <= parity_err_d;
`endif
      end
   end

   assign table_wr_ack  = wr_ack_q;
   assign table_rd_ack  = rd_ack_q;
   assign table_rd_data = rd_data_q;
   assign lookup_vld    = lk_vld_q;
   assign lookup_data   = lk_data_q;
`ifdef GENERIC_TABLE_PARITY_EN
   assign parity_err    = parity_err_q;
`endif

endmodule

// File: tb/tb_generic_table_mem.sv
// tb/tb_generic_table_mem.sv - self-checking bench for generic_table_mem
module tb_generic_table_mem;

   localparam int EW    = 8;
   localparam int AW    = 8;
   localparam int DEPTH = 256;
   localparam int MAXD  = 4;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          table_rd_req;
   logic          table_rd_ack;
   logic [AW-1:0] table_rd_addr;
   logic [EW-1:0] table_rd_data;
   logic          table_wr_req;
   logic          table_wr_ack;
   logic [AW-1:0] table_wr_addr;
   logic [EW-1:0] table_wr_data;
   logic          lookup_req;
   logic [AW-1:0] lookup_addr;
   logic          lookup_rdy;
   logic          lookup_vld;
   logic [EW-1:0] lookup_data;
`ifdef GENERIC_TABLE_PARITY_EN
   logic          parity_err;
`endif

   generic_table_mem #(
      .TABLE_ENTRY_WIDTH (EW),
      .TABLE_ADDR_WIDTH  (AW),
      .TABLE_DEPTH       (DEPTH),
      .MAX_DEFER         (MAXD)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .table_rd_req  (table_rd_req),
      .table_rd_ack  (table_rd_ack),
      .table_rd_addr (table_rd_addr),
      .table_rd_data (table_rd_data),
      .table_wr_req  (table_wr_req),
      .table_wr_ack  (table_wr_ack),
      .table_wr_addr (table_wr_addr),
      .table_wr_data (table_wr_data),
      .lookup_req    (lookup_req),
      .lookup_addr   (lookup_addr),
      .lookup_rdy    (lookup_rdy),
      .lookup_vld    (lookup_vld),
      .lookup_data   (lookup_data)
`ifdef GENERIC_TABLE_PARITY_EN
      ,
      .parity_err    (parity_err)
`endif
   );

   always #5 clk = ~clk;

   int            checks  = 0;
   int            errors  = 0;
   int            rdy_low = 0;
   bit            lk_rand = 1'b0;
   logic [EW-1:0] model [DEPTH];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
   endtask

   // One clock: predict the lookup outcome, advance, check it, and commit any acked write
   task automatic cycle();
      bit            acc;
      logic [EW-1:0] exp_lk;
      if (lk_rand) begin
         lookup_req  = ($urandom_range(0, 1) == 1);
         lookup_addr = AW'($urandom_range(0, DEPTH - 1));
      end
      acc    = (lookup_req === 1'b1) && (lookup_rdy === 1'b1);
      exp_lk = model[lookup_addr];
      if (lookup_rdy !== 1'b1) rdy_low++;
      @(posedge clk);
      #1;
      check("lookup_vld", {31'd0, lookup_vld}, {31'd0, acc});
      if (acc) check("lookup_data", {24'd0, lookup_data}, {24'd0, exp_lk});
      if (table_wr_ack === 1'b1) model[table_wr_addr] = table_wr_data;
   endtask

   task automatic reg_write(input logic [AW-1:0] a, input logic [EW-1:0] d, output int lat);
      table_wr_addr = a;
      table_wr_data = d;
      table_wr_req  = 1'b1;
      lat = 0;
      do begin
         cycle();
         lat++;
      end while (table_wr_ack !== 1'b1 && lat < 20);
      check("wr_ack_seen", {31'd0, table_wr_ack}, 32'd1);
      cycle();
      check("wr_ack_single", {31'd0, table_wr_ack}, 32'd0);
      table_wr_req = 1'b0;
   endtask

   task automatic reg_read(input logic [AW-1:0] a, output int lat, output logic [EW-1:0] d);
      logic [EW-1:0] exp;
      table_rd_addr = a;
      table_rd_req  = 1'b1;
      lat = 0;
      do begin
         cycle();
         lat++;
      end while (table_rd_ack !== 1'b1 && lat < 20);
      check("rd_ack_seen", {31'd0, table_rd_ack}, 32'd1);
      exp = model[a];
      d   = table_rd_data;
      check("rd_data", {24'd0, table_rd_data}, {24'd0, exp});
      cycle();
      check("rd_ack_single", {31'd0, table_rd_ack}, 32'd0);
      check("rd_data_hold", {24'd0, table_rd_data}, {24'd0, exp});
      table_rd_req = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int            lat;
      int            n;
      logic [EW-1:0] rd;
      logic [AW-1:0] ra;
      logic [EW-1:0] rdat;

      model_clear();
      reset_n       = 1'b0;
      table_rd_req  = 1'b0;
      table_rd_addr = '0;
      table_wr_req  = 1'b0;
      table_wr_addr = '0;
      table_wr_data = '0;
      lookup_req    = 1'b1;
      lookup_addr   = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_wr_ack", {31'd0, table_wr_ack}, 32'd0);
      check("rst_rd_ack", {31'd0, table_rd_ack}, 32'd0);
      check("rst_rd_data", {24'd0, table_rd_data}, 32'd0);
      check("rst_lookup_vld", {31'd0, lookup_vld}, 32'd0);
      check("rst_lookup_rdy", {31'd0, lookup_rdy}, 32'd0);
      check("rst_lookup_data", {24'd0, lookup_data}, 32'd0);

      // Zero-fill sweep: lookup port blocked for exactly DEPTH cycles
      reset_n = 1'b1;
      rdy_low = 0;
      repeat (DEPTH) cycle();
      check("sweep_rdy_low_cycles", rdy_low, DEPTH);
      check("rdy_after_sweep", {31'd0, lookup_rdy}, 32'd1);

      lookup_addr = 8'h00;
      cycle();
      check("lookup_addr0", {24'd0, lookup_data}, 32'h00);
      lookup_addr = 8'hFF;
      cycle();
      check("lookup_addr255", {24'd0, lookup_data}, 32'h00);
      lookup_req = 1'b0;
      cycle();

      // Basic write then read
      reg_write(8'h12, 8'hA5, lat);
      check("wr_latency_idle", lat, 1);
      reg_read(8'h12, lat, rd);
      check("rd_latency_idle", lat, 1);
      check("rd_value_A5", {24'd0, rd}, 32'hA5);

      // Lookup data holds after the valid pulse
      lookup_req  = 1'b1;
      lookup_addr = 8'h12;
      cycle();
      lookup_req = 1'b0;
      cycle();
      cycle();
      check("lookup_data_hold", {24'd0, lookup_data}, 32'hA5);

      // Continuous lookups: the write must be forced through
      lookup_req  = 1'b1;
      lookup_addr = 8'h12;
      rdy_low = 0;
      reg_write(8'h30, 8'h77, lat);
      check("defer_latency_bound", {31'd0, (lat <= MAXD + 2)}, 32'd1);
      check("defer_was_deferred", {31'd0, (lat > 1)}, 32'd1);
      check("defer_rdy_low_once", rdy_low, 1);
      lookup_req = 1'b0;
      cycle();
      reg_read(8'h30, lat, rd);

      // Simultaneous read and write on one address: write wins first
      table_wr_addr = 8'h55;
      table_wr_data = 8'h3C;
      table_rd_addr = 8'h55;
      table_wr_req  = 1'b1;
      table_rd_req  = 1'b1;
      n = 0;
      do begin
         cycle();
         n++;
      end while (table_wr_ack !== 1'b1 && n < 20);
      check("sim_wr_ack", {31'd0, table_wr_ack}, 32'd1);
      check("sim_rd_not_first", {31'd0, table_rd_ack}, 32'd0);
      cycle();
      check("sim_wr_ack_single", {31'd0, table_wr_ack}, 32'd0);
      table_wr_req = 1'b0;
      n = 0;
      do begin
         cycle();
         n++;
      end while (table_rd_ack !== 1'b1 && n < 20);
      check("sim_rd_ack", {31'd0, table_rd_ack}, 32'd1);
      check("sim_rd_data_3C", {24'd0, table_rd_data}, 32'h3C);
      cycle();
      check("sim_rd_ack_single", {31'd0, table_rd_ack}, 32'd0);
      table_rd_req = 1'b0;
      cycle();

      // Lookup and write to 0x40 together: old value first, new value next
      lookup_req    = 1'b1;
      lookup_addr   = 8'h40;
      table_wr_addr = 8'h40;
      table_wr_data = 8'h9E;
      table_wr_req  = 1'b1;
      cycle();
      check("collide_old_value", {24'd0, lookup_data}, 32'h00);
      lookup_req = 1'b0;
      n = 0;
      do begin
         cycle();
         n++;
      end while (table_wr_ack !== 1'b1 && n < 20);
      check("collide_wr_ack", {31'd0, table_wr_ack}, 32'd1);
      lookup_req = 1'b1;
      cycle();
      check("collide_vld_next", {31'd0, lookup_vld}, 32'd1);
      check("collide_new_value", {24'd0, lookup_data}, 32'h9E);
      table_wr_req = 1'b0;
      lookup_req   = 1'b0;
      cycle();

      // Random register traffic against random lookups
      lk_rand = 1'b1;
      for (int i = 0; i < 40; i++) begin
         ra   = AW'($urandom_range(0, DEPTH - 1));
         rdat = EW'($urandom_range(0, 255));
         if ($urandom_range(0, 1) == 1) begin
            reg_write(ra, rdat, lat);
         end else begin
            reg_read(ra, lat, rd);
         end
         check("rand_latency_bound", {31'd0, (lat <= MAXD + 2)}, 32'd1);
         repeat ($urandom_range(0, 2)) cycle();
      end
      lk_rand    = 1'b0;
      lookup_req = 1'b0;
      cycle();

      // Reset while wr_ack is high: ack drops at once, sweep reruns
      table_wr_addr = 8'h66;
      table_wr_data = 8'hC3;
      table_wr_req  = 1'b1;
      n = 0;
      do begin
         cycle();
         n++;
      end while (table_wr_ack !== 1'b1 && n < 20);
      check("rst_mid_wr_ack_seen", {31'd0, table_wr_ack}, 32'd1);
      #1;
      reset_n = 1'b0;
      #1;
      check("rst_mid_wr_ack_drop", {31'd0, table_wr_ack}, 32'd0);
      check("rst_mid_lookup_data", {24'd0, lookup_data}, 32'd0);
      table_wr_req = 1'b0;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      model_clear();
      lookup_req  = 1'b1;
      lookup_addr = 8'h66;
      rdy_low = 0;
      repeat (DEPTH) cycle();
      check("resweep_rdy_low_cycles", rdy_low, DEPTH);
      lookup_req = 1'b0;
      cycle();
      reg_read(8'h66, lat, rd);
      check("resweep_entry_zero", {24'd0, rd}, 32'h00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/generic_table_mem.md
Name: generic_table_mem

Overview:
- Table-side responder for the generic table request/ack interface: owns the table storage and answers register-side read and write requests.
- Also serves a one-cycle-latency datapath lookup port.
- Sits between a register block that issues table requests and the datapath lookup logic (e.g. a router's ARP/route tables).
- Includes a lookup-vs-register arbitration scheme, bounded register-access deferral and a zero-fill sweep after reset.

Parameters:
- TABLE_ENTRY_WIDTH, 8: bits per entry.
- TABLE_ADDR_WIDTH, 8: width of all address ports.
- TABLE_DEPTH, 256: number of entries; must be ≤ 2**TABLE_ADDR_WIDTH.
- MAX_DEFER, 4: consecutive cycles a pending register request may be deferred by lookups before it is forced through.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- table_rd_req  in  1  register-side read request; level, held until ack.
- table_rd_ack  out  1  one-cycle read acknowledge.
- table_rd_addr  in  TABLE_ADDR_WIDTH  read address.
- table_rd_data  out  TABLE_ENTRY_WIDTH  read data; valid when table_rd_ack=1, then held.
- table_wr_req  in  1  register-side write request; level, held until ack.
- table_wr_ack  out  1  one-cycle write acknowledge.
- table_wr_addr  in  TABLE_ADDR_WIDTH  write address.
- table_wr_data  in  TABLE_ENTRY_WIDTH  write data.
- lookup_req  in  1  datapath lookup strobe; accepted only when lookup_rdy=1.
- lookup_addr  in  TABLE_ADDR_WIDTH  lookup address.
- lookup_rdy  out  1  lookup port can accept this cycle.
- lookup_vld  out  1  lookup result valid; exactly one cycle after acceptance.
- lookup_data  out  TABLE_ENTRY_WIDTH  lookup result.

Behaviour:
- Reset (async, reset_n=0): all outputs 0; state INIT; sweep address 0; defer counter 0.
- States: INIT, IDLE, WR_ACK, RD_ACK.
- INIT:
  - Writes 0 to entry sweep_addr each cycle, TABLE_DEPTH cycles.
  - lookup_rdy=0; requests are not acked.
  - Moves to IDLE after entry TABLE_DEPTH-1 is written.
  - Reset asserted mid-sweep or mid-operation restarts INIT and drops any ack immediately.
- IDLE priority, evaluated each cycle:
  1. A forced register access (defer counter == MAX_DEFER): lookup_rdy=0 this cycle.
  2. An accepted lookup.
  3. table_wr_req.
  4. table_rd_req.
- Defer counter:
  - Increments each cycle a register request is pending but loses to a lookup.
  - Clears when a register access is served.
- Write service:
  - mem[table_wr_addr] <= table_wr_data; table_wr_ack <= 1; goto WR_ACK.
  - Address ≥ TABLE_DEPTH: no store, still acked.
- Read service:
  - table_rd_data <= mem[table_rd_addr], or 0 if address ≥ TABLE_DEPTH; table_rd_ack <= 1; goto RD_ACK.
- WR_ACK / RD_ACK:
  - ack <= 0; goto IDLE.
  - The requester's req is still high this cycle; it is ignored, so there is no double ack.
  - lookup_rdy=1 and lookups are served in these states.
- Simultaneous rd and wr requests: write first, read on a later IDLE turn.
- Ack timing: ack appears no earlier than one cycle after req is sampled high.
- Lookup:
  - Accepted in cycle N → lookup_vld=1, lookup_data=mem[lookup_addr] in N+1.
  - Address ≥ TABLE_DEPTH returns 0.
  - lookup_vld=0 otherwise; lookup_data holds its last value.
- Same-cycle collisions:
  - A write in cycle N is visible to lookups accepted in N+1 or later.
  - A lookup in N to the same address returns the old data.

Optional Feature:
- Macro: GENERIC_TABLE_PARITY_EN.
- Defined:
  - Each entry stores an extra even-parity bit, computed on write and on INIT zero-fill.
  - Parity is checked on lookup and on register read.
  - Extra output port parity_err (1 bit, reset 0) pulses high with lookup_vld/table_rd_ack when the check fails.
  - Data is returned unmodified.
- Undefined: no parity storage, no parity_err port; behaviour otherwise identical.

Test Plan:
- Release reset, idle 256 cycles with lookup_req=1 → lookup_rdy=0 for the whole sweep; then lookups at addresses 0, 255 return 0x00 with lookup_vld one cycle after acceptance.
- Write addr 0x12 data 0xA5 (hold req until ack), then read 0x12 → single-cycle wr_ack, then single-cycle rd_ack with table_rd_data=0xA5; no second ack while req is still high.
- lookup_req held high continuously, table_wr_req raised → register write acked within MAX_DEFER+2 cycles (6 at default); lookup_rdy low exactly one cycle.
- Raise rd_req and wr_req together on the same address (old 0x00, new 0x3C) → wr_ack first, rd_ack later returns 0x3C.
- Lookup and write to addr 0x40 in the same cycle → lookup returns old value; lookup next cycle returns new value.
- Assert reset_n=0 while wr_ack=1 → wr_ack drops immediately; after reset, the INIT sweep reruns and the entry reads 0x00.
